// File: rtl/mem_ctrl.sv
// Byte-wide memory controller arbitrating ICache fetches and LSB loads/stores.
// Multi-byte requests are serialised one byte per cycle.
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        ic_to_mc_request,
    input  logic [31:0] ic_to_mc_pc,
    output logic        mc_to_ic_rdy,
    output logic [31:0] mc_to_ic_inst,
    input  logic        lsb_to_mc_request,
    input  logic        lsb_to_mc_wr,
    input  logic [31:0] lsb_to_mc_addr,
    input  logic [1:0]  lsb_to_mc_len,
    input  logic [31:0] lsb_to_mc_data,
    output logic        mc_to_lsb_rdy,
    output logic [31:0] mc_to_lsb_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic        r_src_ic;
    logic        r_last_ic;
    logic [31:0] r_buf;
    logic [31:0] r_ic_inst;
    logic [31:0] r_lsb_data;
    logic        r_rdy_d;
    logic [7:0]  r_din_hold;

    logic        w_grant_lsb;
    logic        w_grant_ic;
    logic        w_accept;
    logic        w_io_stall;
    logic        w_rdy_pulse;
    logic [7:0]  w_din;
    logic [7:0]  w_wbyte;
    logic [31:0] w_cur_a;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // After reset r_last_ic=1, so a simultaneous pair goes to the LSB first.
    assign w_grant_lsb = lsb_to_mc_request && (!ic_to_mc_request || r_last_ic);
    assign w_grant_ic  = ic_to_mc_request && !w_grant_lsb;
    assign w_accept    = (r_state == ST_IDLE) && (ic_to_mc_request || lsb_to_mc_request) && !rob_clear;
    assign w_io_stall  = r_wr && (r_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign w_rdy_pulse = (r_state == ST_DONE) && rdy_in && (r_wr || !rob_clear);
    assign w_cur_a     = r_addr + {29'd0, r_cnt};
    // The RAM keeps answering while frozen; the first stalled cycle's byte is the one owed on resume.
    assign w_din       = r_rdy_d ? mem_din : r_din_hold;

    assign mc_to_ic_rdy   = w_rdy_pulse && r_src_ic;
    assign mc_to_lsb_rdy  = w_rdy_pulse && !r_src_ic;
    assign mc_to_ic_inst  = (w_rdy_pulse && r_src_ic) ? r_buf : r_ic_inst;
    assign mc_to_lsb_data = (w_rdy_pulse && !r_src_ic && !r_wr) ? r_buf : r_lsb_data;

    // Select the store byte for the current counter position.
    always_comb begin
        w_wbyte = 8'd0;
        case (r_cnt)
            3'd0:    w_wbyte = r_wdata[7:0];
            3'd1:    w_wbyte = r_wdata[15:8];
            3'd2:    w_wbyte = r_wdata[23:16];
            3'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = 8'd0;
        endcase
    end

    // RAM port drive: address during access cycles, write strobe only on live write cycles.
    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if (r_state == ST_BUSY && r_cnt < r_n) begin
            if (r_wr) begin
                if (!w_io_stall) begin
                    mem_a    = w_cur_a;
                    mem_dout = w_wbyte;
                    mem_wr   = rdy_in;
                end else begin
                    mem_a    = 32'd0;
                end
            end else begin
                mem_a = w_cur_a;
            end
        end else begin
            mem_a = 32'd0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nx = ST_BUSY;
                else          w_state_nx = ST_IDLE;
            end
            ST_BUSY: begin
                if (!r_wr && rob_clear) begin
                    w_state_nx = ST_IDLE;
                end else if (r_wr) begin
                    if (!w_io_stall && r_cnt == r_n - 3'd1) w_state_nx = ST_DONE;
                    else                                     w_state_nx = ST_BUSY;
                end else begin
                    if (r_cnt == r_n) w_state_nx = ST_DONE;
                    else              w_state_nx = ST_BUSY;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in)     r_state <= ST_IDLE;
        else if (rdy_in) r_state <= w_state_nx;
        else             r_state <= r_state;
    end

    // Operand latch, byte counter, read assembly and completion registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cnt      <= 3'd0;
            r_n        <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wr       <= 1'b0;
            r_src_ic   <= 1'b0;
            r_last_ic  <= 1'b1;
            r_buf      <= 32'd0;
            r_ic_inst  <= 32'd0;
            r_lsb_data <= 32'd0;
            r_rdy_d    <= 1'b1;
            r_din_hold <= 8'd0;
        end else begin
            r_rdy_d <= rdy_in;
            if (!rdy_in && r_rdy_d) r_din_hold <= mem_din;
            if (rdy_in) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_cnt     <= 3'd0;
                            r_buf     <= 32'd0;
                            r_src_ic  <= w_grant_ic;
                            r_last_ic <= w_grant_ic;
                            if (w_grant_ic) begin
                                r_addr  <= ic_to_mc_pc;
                                r_n     <= 3'd4;
                                r_wr    <= 1'b0;
                                r_wdata <= 32'd0;
                            end else begin
                                r_addr  <= lsb_to_mc_addr;
                                r_n     <= len_bytes(lsb_to_mc_len);
                                r_wr    <= lsb_to_mc_wr;
                                r_wdata <= lsb_to_mc_data;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (r_wr) begin
                            if (!w_io_stall) r_cnt <= r_cnt + 3'd1;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            case (r_cnt)
                                3'd1:    r_buf[7:0]   <= w_din;
                                3'd2:    r_buf[15:8]  <= w_din;
                                3'd3:    r_buf[23:16] <= w_din;
                                3'd4:    r_buf[31:24] <= w_din;
                                default: r_buf        <= r_buf;
                            endcase
                        end
                    end
                    ST_DONE: begin
                        if (w_rdy_pulse && r_src_ic)           r_ic_inst  <= r_buf;
                        if (w_rdy_pulse && !r_src_ic && !r_wr) r_lsb_data <= r_buf;
                    end
                    default: r_cnt <= 3'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single transactions plus hand sequences
// for arbitration, I/O stall, flush, rdy_in freeze and mid-store reset.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        ic_to_mc_request = 1'b0;
    logic [31:0] ic_to_mc_pc = 32'd0;
    logic        mc_to_ic_rdy;
    logic [31:0] mc_to_ic_inst;
    logic        lsb_to_mc_request = 1'b0;
    logic        lsb_to_mc_wr = 1'b0;
    logic [31:0] lsb_to_mc_addr = 32'd0;
    logic [1:0]  lsb_to_mc_len = 2'd0;
    logic [31:0] lsb_to_mc_data = 32'd0;
    logic        mc_to_lsb_rdy;
    logic [31:0] mc_to_lsb_data;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .ic_to_mc_request(ic_to_mc_request), .ic_to_mc_pc(ic_to_mc_pc),
        .mc_to_ic_rdy(mc_to_ic_rdy), .mc_to_ic_inst(mc_to_ic_inst),
        .lsb_to_mc_request(lsb_to_mc_request), .lsb_to_mc_wr(lsb_to_mc_wr),
        .lsb_to_mc_addr(lsb_to_mc_addr), .lsb_to_mc_len(lsb_to_mc_len),
        .lsb_to_mc_data(lsb_to_mc_data), .mc_to_lsb_rdy(mc_to_lsb_rdy),
        .mc_to_lsb_data(mc_to_lsb_data), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    // RAM model: 256 KiB, one-cycle read latency, preloaded bytes from init_byte
    bit [7:0] wmem [0:262143];
    bit       wvld [0:262143];

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        case (a)
            18'h00100: return 8'h13;
            18'h00101: return 8'h05;
            18'h00102: return 8'h10;
            18'h00103: return 8'h00;
            18'h00200: return 8'hAA;
            18'h00201: return 8'hBB;
            18'h3FFFE: return 8'h11;
            18'h3FFFF: return 8'h22;
            18'h00000: return 8'h33;
            18'h00001: return 8'h44;
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [17:0] a);
        return wvld[a] ? wmem[a] : init_byte(a);
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) begin
            wmem[mem_a[17:0]] <= mem_dout;
            wvld[mem_a[17:0]] <= 1'b1;
        end
        mem_din <= ram_rd(mem_a[17:0]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          is_ic;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    function automatic int nbytes(input vec_t v);
        if (v.is_ic) return 4;
        case (v.len)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Wait (bounded) for a rdy pulse; k=1 is the first cycle after the call
    task automatic wait_rdy(input bit ic, output int cyc, output bit other_seen);
        cyc = -1;
        other_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); #1;
            if (ic ? mc_to_lsb_rdy : mc_to_ic_rdy) other_seen = 1'b1;
            if (ic ? mc_to_ic_rdy : mc_to_lsb_rdy) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int n;
        int got;
        logic [31:0] ea;
        n = nbytes(v);
        got = -1;
        @(negedge clk_in);
        if (v.is_ic) begin
            ic_to_mc_request = 1'b1;
            ic_to_mc_pc      = v.addr;
        end else begin
            lsb_to_mc_request = 1'b1;
            lsb_to_mc_wr      = v.wr;
            lsb_to_mc_addr    = v.addr;
            lsb_to_mc_len     = v.len;
            lsb_to_mc_data    = v.wdata;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); #1;
            if (k <= n) begin
                ea = v.addr + 32'(k - 1);
                chk($sformatf("v%0d_mem_a_k%0d", idx, k), mem_a, ea);
                chk($sformatf("v%0d_mem_wr_k%0d", idx, k), {31'd0, mem_wr}, {31'd0, v.wr});
                if (v.wr) chk($sformatf("v%0d_dout_k%0d", idx, k), {24'd0, mem_dout}, {24'd0, v.wdata[8*(k-1) +: 8]});
            end
            if (v.is_ic ? mc_to_ic_rdy : mc_to_lsb_rdy) begin
                got = k;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), got, v.lat);
        if (!v.wr) begin
            chk($sformatf("v%0d_rdata", idx), v.is_ic ? mc_to_ic_inst : mc_to_lsb_data, v.exp);
        end else begin
            for (int i = 0; i < n; i++) begin
                ea = v.addr + 32'(i);
                chk($sformatf("v%0d_ram_b%0d", idx, i), {24'd0, ram_rd(ea[17:0])}, {24'd0, v.wdata[8*i +: 8]});
            end
        end
        @(negedge clk_in);
        ic_to_mc_request  = 1'b0;
        lsb_to_mc_request = 1'b0;
        lsb_to_mc_wr      = 1'b0;
    endtask

    // Both sources request at once: IC fetch 0x100, LSB load 0x200 len 2
    task automatic pair(input int id, input bit lsb_first);
        int cyc;
        bit other;
        @(negedge clk_in);
        ic_to_mc_request  = 1'b1;
        ic_to_mc_pc       = 32'h100;
        lsb_to_mc_request = 1'b1;
        lsb_to_mc_wr      = 1'b0;
        lsb_to_mc_addr    = 32'h200;
        lsb_to_mc_len     = 2'd1;
        wait_rdy(!lsb_first, cyc, other);
        chk($sformatf("pair%0d_first_lat", id), cyc, lsb_first ? 4 : 6);
        chk($sformatf("pair%0d_first_other_rdy", id), {31'd0, other}, 32'd0);
        chk($sformatf("pair%0d_first_data", id), lsb_first ? mc_to_lsb_data : mc_to_ic_inst,
            lsb_first ? 32'h0000BBAA : 32'h00100513);
        @(negedge clk_in);
        if (lsb_first) lsb_to_mc_request = 1'b0;
        else           ic_to_mc_request  = 1'b0;
        wait_rdy(lsb_first, cyc, other);
        chk($sformatf("pair%0d_second_lat", id), cyc, lsb_first ? 7 : 5);
        chk($sformatf("pair%0d_second_data", id), lsb_first ? mc_to_ic_inst : mc_to_lsb_data,
            lsb_first ? 32'h00100513 : 32'h0000BBAA);
        @(negedge clk_in);
        ic_to_mc_request  = 1'b0;
        lsb_to_mc_request = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  other;
        bit  seen;

        vecs[0] = '{1'b1, 1'b0, 32'h00000100, 2'd2, 32'h0,        32'h00100513, 6};
        vecs[1] = '{1'b0, 1'b0, 32'h00000200, 2'd1, 32'h0,        32'h0000BBAA, 4};
        vecs[2] = '{1'b0, 1'b0, 32'h00000201, 2'd0, 32'h0,        32'h000000BB, 3};
        vecs[3] = '{1'b0, 1'b1, 32'h00000300, 2'd2, 32'hDEADBEEF, 32'h0,        5};
        vecs[4] = '{1'b0, 1'b0, 32'h00000300, 2'd2, 32'h0,        32'hDEADBEEF, 6};
        vecs[5] = '{1'b0, 1'b1, 32'h00000310, 2'd1, 32'h12345678, 32'h0,        3};
        vecs[6] = '{1'b0, 1'b0, 32'h00000310, 2'd2, 32'h0,        32'h00005678, 6};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFFFFFE, 2'd2, 32'h0,        32'h44332211, 6};
        vecs[8] = '{1'b0, 1'b0, 32'h00000302, 2'd1, 32'h0,        32'h0000DEAD, 4};

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_ic_rdy", {31'd0, mc_to_ic_rdy}, 32'd0);
        chk("rst_lsb_rdy", {31'd0, mc_to_lsb_rdy}, 32'd0);
        chk("rst_ic_inst", mc_to_ic_inst, 32'd0);
        chk("rst_lsb_data", mc_to_lsb_data, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Round-robin arbitration
        pair(1, 1'b1);
        pair(2, 1'b1);
        run_txn(100, vecs[1]);
        pair(3, 1'b0);

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

        // I/O write stalled by a full buffer for three cycles
        @(negedge clk_in);
        lsb_to_mc_request = 1'b1;
        lsb_to_mc_wr      = 1'b1;
        lsb_to_mc_addr    = 32'h00030000;
        lsb_to_mc_len     = 2'd0;
        lsb_to_mc_data    = 32'h00000041;
        io_buffer_full    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_in); #1;
            chk($sformatf("io_stall_wr_k%0d", k), {31'd0, mem_wr}, 32'd0);
            chk($sformatf("io_stall_rdy_k%0d", k), {31'd0, mc_to_lsb_rdy}, 32'd0);
        end
        @(posedge clk_in); #1;
        io_buffer_full = 1'b0;
        #1;
        chk("io_resume_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_resume_dout", {24'd0, mem_dout}, 32'h41);
        chk("io_resume_a", mem_a, 32'h00030000);
        @(posedge clk_in); #1;
        chk("io_rdy", {31'd0, mc_to_lsb_rdy}, 32'd1);
        @(negedge clk_in);
        lsb_to_mc_request = 1'b0;
        lsb_to_mc_wr      = 1'b0;
        chk("io_ram", {24'd0, ram_rd(18'h30000)}, 32'h41);

        // Flush at A+3 of an IC fetch aborts it
        @(negedge clk_in);
        ic_to_mc_request = 1'b1;
        ic_to_mc_pc      = 32'h100;
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        rob_clear        = 1'b1;
        ic_to_mc_request = 1'b0;
        @(posedge clk_in); #1;
        rob_clear = 1'b0;
        chk("flush_idle_mem_a", mem_a, 32'd0);
        seen = mc_to_ic_rdy;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in); #1;
            if (mc_to_ic_rdy) seen = 1'b1;
        end
        chk("flush_no_ic_rdy", {31'd0, seen}, 32'd0);

        // Flush at A+2 of a 4-byte store is ignored
        @(negedge clk_in);
        lsb_to_mc_request = 1'b1;
        lsb_to_mc_wr      = 1'b1;
        lsb_to_mc_addr    = 32'h400;
        lsb_to_mc_len     = 2'd2;
        lsb_to_mc_data    = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk_in); #1;
        end
        rob_clear = 1'b1;
        @(posedge clk_in); #1;
        rob_clear = 1'b0;
        wait_rdy(1'b0, cyc, other);
        chk("flush_store_lat", cyc, 2);
        chk("flush_store_ram", {ram_rd(18'h403), ram_rd(18'h402), ram_rd(18'h401), ram_rd(18'h400)}, 32'hCAFEF00D);
        @(negedge clk_in);
        lsb_to_mc_request = 1'b0;
        lsb_to_mc_wr      = 1'b0;

        // rdy_in low for two edges mid-fetch delays the result by two cycles
        @(negedge clk_in);
        ic_to_mc_request = 1'b1;
        ic_to_mc_pc      = 32'h100;
        @(posedge clk_in); #1;
        chk("frz_a_k1", mem_a, 32'h100);
        @(posedge clk_in); #1;
        chk("frz_a_k2", mem_a, 32'h101);
        rdy_in = 1'b0;
        @(posedge clk_in); #1;
        chk("frz_a_k3", mem_a, 32'h101);
        chk("frz_wr_k3", {31'd0, mem_wr}, 32'd0);
        @(posedge clk_in); #1;
        chk("frz_a_k4", mem_a, 32'h101);
        rdy_in = 1'b1;
        wait_rdy(1'b1, cyc, other);
        chk("frz_lat", cyc, 4);
        chk("frz_inst", mc_to_ic_inst, 32'h00100513);
        @(negedge clk_in);
        ic_to_mc_request = 1'b0;

        // Reset in the middle of a store
        @(negedge clk_in);
        lsb_to_mc_request = 1'b1;
        lsb_to_mc_wr      = 1'b1;
        lsb_to_mc_addr    = 32'h500;
        lsb_to_mc_len     = 2'd2;
        lsb_to_mc_data    = 32'h11223344;
        repeat (2) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        chk("mrst_mem_a", mem_a, 32'd0);
        chk("mrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("mrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("mrst_ic_inst", mc_to_ic_inst, 32'd0);
        chk("mrst_lsb_data", mc_to_lsb_data, 32'd0);
        rst_in            = 1'b1;
        lsb_to_mc_request = 1'b0;
        lsb_to_mc_wr      = 1'b0;
        seen = mc_to_lsb_rdy;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in); #1;
            if (mc_to_lsb_rdy || mem_wr) seen = 1'b1;
        end
        chk("mrst_no_rdy_or_wr", {31'd0, seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
